// File: rtl/cursor_pkg.sv
// Shared constants and types for the cursor controller.
// Button indices, arbitration order and the per-button state enum.
package cursor_pkg;

    localparam int NUM_BTN = 5;

    typedef logic [2:0] btn_idx_t;

    localparam btn_idx_t BTN_UP     = 3'd0;
    localparam btn_idx_t BTN_DOWN   = 3'd1;
    localparam btn_idx_t BTN_LEFT   = 3'd2;
    localparam btn_idx_t BTN_RIGHT  = 3'd3;
    localparam btn_idx_t BTN_CENTER = 3'd4;

    // Highest priority first.
    localparam btn_idx_t PRIO [NUM_BTN] = '{
        BTN_CENTER, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT
    };

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } btn_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cursor_ctrl_btn_repeat.sv
// One push-button: 2-flop synchronizer, press detector and
// hold-to-repeat timer producing single-cycle event pulses.
module btn_repeat
    import cursor_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_event
);

    localparam int CW = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    btn_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_event;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_event <= 1'b0;
        end else begin
            r_event <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (r_sync) begin
                        r_event <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= HELD;
                    end
                end
                HELD: begin
                    if (!r_sync) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (!REPEAT_EN) begin
                        // Non-repeating button parks here until release.
                        r_cnt <= '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_event <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= REPEAT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!r_sync) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (r_cnt == REP_LAST) begin
                        r_event <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_event = r_event;

endmodule

// File: rtl/cursor_ctrl.sv
// Cursor controller: five debounced/repeating buttons, fixed-priority
// arbitration and registered grid position with wrap or saturate.
module cursor_ctrl
    import cursor_pkg::*;
#(
    parameter int COLS          = 8,
    parameter int ROWS          = 4,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter bit WRAP          = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4:0]                btn_raw,
    input  logic                      lock,
    output logic [$clog2(COLS)-1:0]   cur_x,
    output logic [$clog2(ROWS)-1:0]   cur_y,
    output logic                      moved,
    output logic                      edge_hit,
    output logic                      sel_pulse
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

    logic [NUM_BTN-1:0] w_event;
    btn_idx_t           w_win;
    logic               w_any;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_moved;
    logic          r_edge;
    logic          r_sel;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_repeat #(
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .REPEAT_EN    (g != int'(BTN_CENTER))
        ) u_btn (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_raw  (btn_raw[g]),
            .o_event(w_event[g])
        );
    end

    // Walk lowest priority first so the highest one present wins.
    always_comb begin
        w_win = BTN_CENTER;
        w_any = 1'b0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (w_event[PRIO[i]]) begin
                w_win = PRIO[i];
                w_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_moved <= 1'b0;
            r_edge  <= 1'b0;
            r_sel   <= 1'b0;
        end else begin
            r_moved <= 1'b0;
            r_edge  <= 1'b0;
            r_sel   <= 1'b0;
            if (w_any && !lock) begin
                unique case (w_win)
                    BTN_CENTER: r_sel <= 1'b1;
                    BTN_UP: begin
                        if (r_y != '0) begin
                            r_y     <= r_y - 1'b1;
                            r_moved <= 1'b1;
                        end else if (WRAP) begin
                            r_y     <= Y_MAX;
                            r_moved <= 1'b1;
                        end else begin
                            r_edge <= 1'b1;
                        end
                    end
                    BTN_DOWN: begin
                        if (r_y != Y_MAX) begin
                            r_y     <= r_y + 1'b1;
                            r_moved <= 1'b1;
                        end else if (WRAP) begin
                            r_y     <= '0;
                            r_moved <= 1'b1;
                        end else begin
                            r_edge <= 1'b1;
                        end
                    end
                    BTN_LEFT: begin
                        if (r_x != '0) begin
                            r_x     <= r_x - 1'b1;
                            r_moved <= 1'b1;
                        end else if (WRAP) begin
                            r_x     <= X_MAX;
                            r_moved <= 1'b1;
                        end else begin
                            r_edge <= 1'b1;
                        end
                    end
                    BTN_RIGHT: begin
                        if (r_x != X_MAX) begin
                            r_x     <= r_x + 1'b1;
                            r_moved <= 1'b1;
                        end else if (WRAP) begin
                            r_x     <= '0;
                            r_moved <= 1'b1;
                        end else begin
                            r_edge <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cur_x     = r_x;
    assign cur_y     = r_y;
    assign moved     = r_moved;
    assign edge_hit  = r_edge;
    assign sel_pulse = r_sel;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Bench for cursor_ctrl: wrapping and saturating instances side by side,
// directed scenarios plus random stimulus against a run-length model.
module tb_cursor_ctrl;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int HOLD = 10;
    localparam int REP  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn_raw = '0;
    logic       lock = 1'b0;

    logic [1:0] x1, y1, x0, y0;
    logic       mv1, eh1, sp1, mv0, eh0, sp0;
    logic [6:0] o1, o0;

    assign o1 = {x1, y1, mv1, eh1, sp1};
    assign o0 = {x0, y0, mv0, eh0, sp0};

    cursor_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .WRAP(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .lock(lock),
        .cur_x(x1), .cur_y(y1), .moved(mv1),
        .edge_hit(eh1), .sel_pulse(sp1)
    );

    cursor_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .WRAP(1'b0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .lock(lock),
        .cur_x(x0), .cur_y(y0), .moved(mv0),
        .edge_hit(eh0), .sel_pulse(sp0)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // Model: index 0 = saturating instance, 1 = wrapping instance.
    logic [4:0] m_q[$];
    int         m_h[5];
    logic [4:0] m_pend;
    int         mx[2], my[2];
    logic       mmv[2], meh[2], msp[2];

    function automatic void model_clear();
        m_q = '{5'd0, 5'd0};
        m_pend = '0;
        for (int b = 0; b < 5; b++) m_h[b] = 0;
        for (int k = 0; k < 2; k++) begin
            mx[k] = 0; my[k] = 0;
            mmv[k] = 0; meh[k] = 0; msp[k] = 0;
        end
    endfunction

    function automatic void model_edge();
        logic [4:0] seen, ev;
        int dx, dy, nx, ny;
        seen = m_q.pop_front();
        m_q.push_back(btn_raw);
        for (int k = 0; k < 2; k++) begin
            mmv[k] = 0; meh[k] = 0; msp[k] = 0;
        end
        if (m_pend != 0 && !lock) begin
            if (m_pend[4]) begin
                msp[0] = 1; msp[1] = 1;
            end else begin
                dx = 0; dy = 0;
                if (m_pend[0]) dy = -1;
                else if (m_pend[1]) dy = 1;
                else if (m_pend[2]) dx = -1;
                else dx = 1;
                for (int k = 0; k < 2; k++) begin
                    nx = mx[k] + dx;
                    ny = my[k] + dy;
                    if (nx < 0 || nx >= COLS || ny < 0 || ny >= ROWS) begin
                        if (k == 1) begin
                            mx[k] = (nx + COLS) % COLS;
                            my[k] = (ny + ROWS) % ROWS;
                            mmv[k] = 1;
                        end else begin
                            meh[k] = 1;
                        end
                    end else begin
                        mx[k] = nx; my[k] = ny; mmv[k] = 1;
                    end
                end
            end
        end
        // Events follow from how long each button has been seen held.
        for (int b = 0; b < 5; b++) begin
            m_h[b] = seen[b] ? m_h[b] + 1 : 0;
            ev[b] = (m_h[b] == 1) ||
                    (b != 4 && m_h[b] > HOLD &&
                     (m_h[b] - 1 - HOLD) % REP == 0);
        end
        m_pend = ev;
    endfunction

    function automatic logic [6:0] exp_vec(input int k);
        return {2'(mx[k]), 2'(my[k]), mmv[k], meh[k], msp[k]};
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_clear();
        else model_edge();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic tap(input int b);
        btn_raw[b] = 1'b1;
        run(3);
        btn_raw[b] = 1'b0;
        run(5);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn_raw = '0;
        lock = 1'b0;
        model_clear();
        run(2);
        rst_n = 1'b1;
        run(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn_raw = '0;
        lock = 1'b0;
        model_clear();
        run(2);
        n_chk++;
        if ({o1, o0} !== 14'd0)
            $display("FAIL reset_low: got %h want 0", {o1, o0});
        else n_pass++;
        rst_n = 1'b1;
        run(3);
        n_chk++;
        if ({o1, o0} !== 14'd0)
            $display("FAIL reset_idle: got %h want 0", {o1, o0});
        else n_pass++;
    endtask

    task automatic test_tap_right();
        logic [2:0] want;
        btn_raw[3] = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step();
            if (t == 2) btn_raw[3] = 1'b0;
            want = {(t >= 3) ? 2'd1 : 2'd0, t == 3};
            n_chk++;
            if ({x1, mv1} !== want || {x0, mv0} !== want)
                $display("FAIL tap_right t=%0d: got %h/%h want %h",
                         t, {x1, mv1}, {x0, mv0}, want);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_edge();
        int c_mv1, c_mv0, c_eh0;
        tap(3);
        tap(3);
        c_mv1 = 0; c_mv0 = 0; c_eh0 = 0;
        btn_raw[3] = 1'b1;
        for (int t = 0; t < 8; t++) begin
            step();
            if (t == 2) btn_raw[3] = 1'b0;
            c_mv1 += int'(mv1);
            c_mv0 += int'(mv0);
            c_eh0 += int'(eh0);
        end
        n_chk++;
        if (x1 !== 2'd0 || c_mv1 != 1)
            $display("FAIL wrap_right: got x=%0d moves=%0d want x=0 moves=1",
                     x1, c_mv1);
        else n_pass++;
        n_chk++;
        if (x0 !== 2'd3 || c_mv0 != 0 || c_eh0 != 1)
            $display("FAIL sat_right: got x=%0d mv=%0d eh=%0d want 3 0 1",
                     x0, c_mv0, c_eh0);
        else n_pass++;
    endtask

    task automatic test_hold_down();
        int et[6] = '{3, 13, 17, 21, 25, 29};
        int ey[6] = '{1, 2, 0, 1, 2, 0};
        int k;
        do_reset();
        k = 0;
        btn_raw[1] = 1'b1;
        for (int t = 0; t < 40; t++) begin
            step();
            if (t == 29) btn_raw[1] = 1'b0;
            if (mv1) begin
                n_chk++;
                if (k >= 6 || t != et[k] || y1 !== 2'(ey[k]))
                    $display("FAIL hold_down move %0d: got t=%0d y=%0d",
                             k, t, y1);
                else n_pass++;
                k++;
            end
            for (int w = 0; w < 2; w++) begin
                n_chk++;
                if ((w != 0 ? o1 : o0) !== exp_vec(w))
                    $display("FAIL hold_down_model w%0d t=%0d: got %h want %h",
                             w, t, (w != 0 ? o1 : o0), exp_vec(w));
                else n_pass++;
            end
        end
        n_chk++;
        if (k != 6)
            $display("FAIL hold_down_count: got %0d want 6", k);
        else n_pass++;
    endtask

    task automatic test_center_hold();
        int c_sel1, c_sel0, c_mv;
        c_sel1 = 0; c_sel0 = 0; c_mv = 0;
        btn_raw[4] = 1'b1;
        for (int t = 0; t < 40; t++) begin
            step();
            if (t == 29) btn_raw[4] = 1'b0;
            c_sel1 += int'(sp1);
            c_sel0 += int'(sp0);
            c_mv += int'(mv1) + int'(mv0) + int'(eh1) + int'(eh0);
        end
        n_chk++;
        if (c_sel1 != 1 || c_sel0 != 1 || c_mv != 0)
            $display("FAIL center_hold: got sel=%0d/%0d moves=%0d want 1/1 0",
                     c_sel1, c_sel0, c_mv);
        else n_pass++;
        n_chk++;
        if ({x1, y1, x0, y0} !== {2'd0, 2'd0, 2'd0, 2'd2})
            $display("FAIL center_pos: got %h want 02", {x1, y1, x0, y0});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int c_mv, c_sel;
        do_reset();
        tap(3); tap(3); tap(1); tap(1);
        c_mv = 0;
        btn_raw = 5'b00101;
        for (int t = 0; t < 8; t++) begin
            step();
            if (t == 2) btn_raw = '0;
            c_mv += int'(mv1) + int'(mv0);
        end
        n_chk++;
        if ({x1, y1, x0, y0} !== {2'd2, 2'd1, 2'd2, 2'd1} || c_mv != 2)
            $display("FAIL up_left: got %h moves=%0d want 9 9 moves=2",
                     {x1, y1, x0, y0}, c_mv);
        else n_pass++;
        c_mv = 0; c_sel = 0;
        btn_raw = 5'b11000;
        for (int t = 0; t < 8; t++) begin
            step();
            if (t == 2) btn_raw = '0;
            c_mv += int'(mv1) + int'(mv0);
            c_sel += int'(sp1) + int'(sp0);
        end
        n_chk++;
        if ({x1, y1} !== {2'd2, 2'd1} || c_mv != 0 || c_sel != 2)
            $display("FAIL center_right: got %h mv=%0d sel=%0d want 9 0 2",
                     {x1, y1}, c_mv, c_sel);
        else n_pass++;
    endtask

    task automatic test_lock();
        int c_p;
        lock = 1'b1;
        c_p = 0;
        btn_raw[3] = 1'b1;
        for (int t = 0; t < 8; t++) begin
            step();
            if (t == 2) btn_raw[3] = 1'b0;
            c_p += int'(mv1) + int'(eh1) + int'(sp1);
        end
        n_chk++;
        if (x1 !== 2'd2 || c_p != 0)
            $display("FAIL lock_tap: got x=%0d pulses=%0d want 2 0", x1, c_p);
        else n_pass++;
        btn_raw[3] = 1'b1;
        for (int t = 0; t < 26; t++) begin
            step();
            if (t == 5) lock = 1'b0;
            if (t == 19) btn_raw[3] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                n_chk++;
                if ((w != 0 ? o1 : o0) !== exp_vec(w))
                    $display("FAIL lock_hold w%0d t=%0d: got %h want %h",
                             w, t, (w != 0 ? o1 : o0), exp_vec(w));
                else n_pass++;
            end
        end
        n_chk++;
        if (x1 !== 2'd1 || x0 !== 2'd3)
            $display("FAIL lock_unlock: got x=%0d/%0d want 1/3", x1, x0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        int first_t, second_t;
        btn_raw = 5'b01000;
        run(12);
        rst_n = 1'b0;
        model_clear();
        #1;
        n_chk++;
        if ({o1, o0} !== 14'd0)
            $display("FAIL rst_async: got %h want 0", {o1, o0});
        else n_pass++;
        run(2);
        n_chk++;
        if ({o1, o0} !== 14'd0)
            $display("FAIL rst_hold: got %h want 0", {o1, o0});
        else n_pass++;
        rst_n = 1'b1;
        first_t = -1; second_t = -1;
        for (int t = 0; t < 20; t++) begin
            step();
            if (mv1 && first_t < 0) first_t = t;
            else if (mv1 && second_t < 0) second_t = t;
        end
        btn_raw = '0;
        run(4);
        n_chk++;
        if (first_t != 3 || second_t != 3 + HOLD)
            $display("FAIL rst_rehold: got t=%0d,%0d want 3,%0d",
                     first_t, second_t, 3 + HOLD);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 19) == 0) btn_raw[b] = ~btn_raw[b];
            lock = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                model_clear();
                run(2);
                rst_n = 1'b1;
            end
            step();
            for (int w = 0; w < 2; w++) begin
                n_chk++;
                if ((w != 0 ? o1 : o0) !== exp_vec(w))
                    $display("FAIL random w%0d t=%0d: got %h want %h",
                             w, t, (w != 0 ? o1 : o0), exp_vec(w));
                else n_pass++;
            end
        end
        btn_raw = '0;
        lock = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_tap_right();
        test_wrap_edge();
        test_hold_down();
        test_center_hold();
        test_back_to_back();
        test_lock();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cursor_ctrl.md
# cursor_ctrl

- Converts five raw push-buttons (up, down, left, right, center) into a registered cursor position on a COLS×ROWS grid, plus a select strobe.
- Each button has its own synchronizer, press detector and hold-to-repeat timer. Same-cycle events are arbitrated by fixed priority.
- Sits between the board buttons and the menu/display logic. Downstream blocks only read the cursor outputs.

## Interface
- COLS, 8, grid columns (≥2)
- ROWS, 4, grid rows (≥2)
- HOLD_CYCLES, 50_000_000, cycles a direction button must stay held before the first auto-repeat (≥2)
- REPEAT_CYCLES, 10_000_000, cycles between auto-repeats after the first (≥2)
- WRAP, 1, 1 = wrap at grid edges, 0 = saturate
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_raw  in  5  raw buttons, asynchronous; [0]=up [1]=down [2]=left [3]=right [4]=center
- lock  in  1  synchronous; when high, moves and selects are discarded and position holds
- cur_x  out  $clog2(COLS)  cursor column; reset 0
- cur_y  out  $clog2(ROWS)  cursor row; reset 0
- moved  out  1  one-cycle pulse when cur_x/cur_y changed; reset 0
- edge_hit  out  1  one-cycle pulse when a move was blocked at an edge (WRAP=0 only); reset 0
- sel_pulse  out  1  one-cycle select strobe, center press; reset 0

## Operation
- Each button is synchronized through two flops, then fed to a per-button FSM.
- Per-button FSM states: IDLE, HELD, REPEAT.
  - IDLE: on sync=1, emit an event pulse, clear the counter, go to HELD.
  - HELD: increment the counter. When counter==HOLD_CYCLES-1, emit an event, clear the counter, go to REPEAT.
  - REPEAT: increment the counter. When counter==REPEAT_CYCLES-1, emit an event and clear the counter.
  - HELD/REPEAT: sync=0 returns the FSM to IDLE immediately. The counter clears and no event is emitted.
- Center never leaves HELD via the timer, so it does not auto-repeat. It produces exactly one event per press.
- Counter width is $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)). The counter never wraps, since it always clears on match.
- Arbitration applies when more than one event fires in a cycle. Priority: center > up > down > left > right.
  - Only the winner acts. Losing events are dropped, not queued.
- Moves:
  - up: y-1
  - down: y+1
  - left: x-1
  - right: x+1
- Edge behaviour:
  - WRAP=1: 0-1 gives max; max+1 gives 0. moved=1.
  - WRAP=0: the position holds, moved=0, edge_hit=1.
  - max is COLS-1 for x and ROWS-1 for y.
- Center win: sel_pulse=1 and the position is unchanged.
- lock=1 in the arbitration cycle: the event is consumed and no output pulses.
  - The button FSMs keep running under lock, so holding through a lock period still repeats after unlock.
- Reset mid-hold: all FSMs go to IDLE and the position goes to (0,0).
  - If a button is still held when rst_n rises, it produces a fresh press event after synchronization.

## Timing
- Take btn_raw rising and stable before edge N as the reference point:
  - sync output is high after edge N+1.
  - The FSM event is registered at edge N+2.
  - cur_x/cur_y/moved/edge_hit/sel_pulse update at edge N+3.
- Press-to-output latency is 3 cycles.
- The first repeat event occurs HOLD_CYCLES cycles after the press event.
- Subsequent repeat events are spaced every REPEAT_CYCLES cycles.
- All output pulses are exactly one cycle wide and never asserted together.
- Release to IDLE takes effect 2 cycles after btn_raw falls (synchronizer delay).
- A release and a timer match in the same cycle resolve to release, with no event.

## Structure
- Shared package cursor_pkg holds:
  - button index constants BTN_UP..BTN_CENTER
  - the priority order
  - the state enum {IDLE, HELD, REPEAT}
- Sub-module btn_repeat contains the synchronizer, per-button FSM and counter.
  - Parameters: HOLD_CYCLES, REPEAT_CYCLES, REPEAT_EN.
  - Instantiated 5×; center uses REPEAT_EN=0.
- The top level contains the priority arbiter and the position registers.

## Test plan
Benches use COLS=4, ROWS=3, HOLD_CYCLES=10, REPEAT_CYCLES=4.
- Reset, then tap right (high 3 cycles) from (0,0): cur_x=1 three cycles after the raw rise, moved one cycle, no repeat.
- WRAP=1, x=3, tap right: x=0 and moved=1. WRAP=0, x=3, tap right: x=3, edge_hit=1, moved=0.
- Hold down 30 cycles from y=0: moves at press+3, +13, +17, +21, +25, +29. With WRAP=1, y sequence is 1,2,0,1,2,0.
- Hold center 30 cycles: exactly one sel_pulse, position unchanged.
- up and left rise in the same cycle at (2,2): only up acts, giving (2,1), and left is dropped. center and right together: only sel_pulse.
- Hold right, assert rst_n=0 for 2 cycles at cycle 12, release reset with right still held:
  - outputs show (0,0) during reset.
  - a fresh move to x=1 occurs 3 cycles after reset release.
  - the next repeat follows a full HOLD_CYCLES.
